// File: rtl/fb_clear_arbiter_if.sv
// Handshake bundle shared by the rasterizer, the clear arbiter and the framebuffer write port.
// The master side drives the requests; the slave side (the arbiter) drives the write port.
interface fb_clear_arbiter_if #(
   parameter int Z_WIDTH = 15
);
   logic               frame_start_in;
   logic               clear_en_in;
   logic               rast_valid_in;
   logic [26:0]        rast_addr_in;
   logic [Z_WIDTH-1:0] rast_depth_in;
   logic [15:0]        rast_color_in;
   logic               rast_ready_out;
   logic               valid_out;
   logic               ready_in;
   logic [26:0]        addr_out;
   logic [Z_WIDTH-1:0] depth_out;
   logic [15:0]        color_out;
   logic               force_write_out;
   logic               clearing_out;
   logic               clear_done_out;
   logic [15:0]        frame_count_out;

   modport master (
      output frame_start_in, clear_en_in, rast_valid_in, rast_addr_in,
             rast_depth_in, rast_color_in, ready_in,
      input  rast_ready_out, valid_out, addr_out, depth_out, color_out,
             force_write_out, clearing_out, clear_done_out, frame_count_out
   );

   modport slave (
      input  frame_start_in, clear_en_in, rast_valid_in, rast_addr_in,
             rast_depth_in, rast_color_in, ready_in,
      output rast_ready_out, valid_out, addr_out, depth_out, color_out,
             force_write_out, clearing_out, clear_done_out, frame_count_out
   );
endinterface

// File: rtl/fb_clear_arbiter.sv
// Shares the framebuffer write port between rasterizer fragments and a full-screen
// clear sweep (clear colour, max depth, depth test bypassed) started on each frame.
module fb_clear_arbiter #(
   parameter int          Z_WIDTH     = 15,
   parameter int          HRES        = 320,
   parameter int          VRES        = 180,
   parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
   input  logic               clk_in,
   input  logic               rst_in,
   fb_clear_arbiter_if.slave  bus
);

   localparam int DEPTH = HRES * VRES;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [0:0] {
      S_PASS  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t          r_state;
   logic [AW-1:0]   r_clear_addr;
   logic            r_pend;
   logic            r_clearing;
   logic            r_force_write;
   logic            r_clear_done;
   logic [15:0]     r_frame_count;

   logic            w_request;
   logic            w_accept;
   logic            w_last_beat;

   assign w_request   = bus.frame_start_in & bus.clear_en_in;
   assign w_accept    = (r_state == S_CLEAR) & bus.ready_in;
   assign w_last_beat = w_accept & (r_clear_addr == LAST_ADDR);

   // Sweep FSM: owns state, sweep address, pending restart and status outputs.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state       <= S_PASS;
         r_clear_addr  <= {AW{1'b0}};
         r_pend        <= 1'b0;
         r_clearing    <= 1'b0;
         r_force_write <= 1'b0;
         r_clear_done  <= 1'b0;
         r_frame_count <= 16'd0;
      end else begin
         r_clear_done <= 1'b0;
         case (r_state)
            S_PASS: begin
               if (w_request) begin
                  r_state       <= S_CLEAR;
                  r_clear_addr  <= {AW{1'b0}};
                  r_clearing    <= 1'b1;
                  r_force_write <= 1'b1;
               end else begin
                  r_state       <= S_PASS;
               end
            end
            S_CLEAR: begin
               if (w_last_beat) begin
                  r_clear_done  <= 1'b1;
                  r_frame_count <= r_frame_count + 16'd1;
                  r_clear_addr  <= {AW{1'b0}};
                  r_pend        <= 1'b0;
                  // Any request seen during the sweep (or on its last beat) collapses into one restart.
                  if (r_pend || w_request) begin
                     r_state       <= S_CLEAR;
                  end else begin
                     r_state       <= S_PASS;
                     r_clearing    <= 1'b0;
                     r_force_write <= 1'b0;
                  end
               end else begin
                  if (w_accept) begin
                     r_clear_addr <= r_clear_addr + AW'(1);
                  end else begin
                     r_clear_addr <= r_clear_addr;
                  end
                  if (w_request) begin
                     r_pend <= 1'b1;
                  end else begin
                     r_pend <= r_pend;
                  end
               end
            end
            default: begin
               r_state       <= S_PASS;
               r_clear_addr  <= {AW{1'b0}};
               r_pend        <= 1'b0;
               r_clearing    <= 1'b0;
               r_force_write <= 1'b0;
            end
         endcase
      end
   end

   // Write-port mux: zero-latency pass-through in PASS, sweep beat in CLEAR.
   always_comb begin
      bus.valid_out      = bus.rast_valid_in;
      bus.addr_out       = bus.rast_addr_in;
      bus.depth_out      = bus.rast_depth_in;
      bus.color_out      = bus.rast_color_in;
      bus.rast_ready_out = bus.ready_in;
      if (r_state == S_CLEAR) begin
         bus.valid_out      = 1'b1;
         bus.addr_out       = 27'(r_clear_addr);
         bus.depth_out      = {Z_WIDTH{1'b1}};
         bus.color_out      = CLEAR_COLOR;
         bus.rast_ready_out = 1'b0;
      end else begin
         bus.valid_out      = bus.rast_valid_in;
         bus.rast_ready_out = bus.ready_in;
      end
   end

   assign bus.force_write_out = r_force_write;
   assign bus.clearing_out    = r_clearing;
   assign bus.clear_done_out  = r_clear_done;
   assign bus.frame_count_out = r_frame_count;

endmodule

// File: tb/tb_fb_clear_arbiter.sv
// Directed and randomized checks of fb_clear_arbiter (HRES=4, VRES=2) against a
// behavioural sweep model plus a per-sweep address scoreboard.
module tb_fb_clear_arbiter;

   localparam int ZW    = 15;
   localparam int HR    = 4;
   localparam int VR    = 2;
   localparam int DEPTH = HR * VR;

   logic clk_in = 1'b0;
   logic rst_in;

   fb_clear_arbiter_if #(.Z_WIDTH(ZW)) bus ();

   fb_clear_arbiter #(
      .Z_WIDTH     (ZW),
      .HRES        (HR),
      .VRES        (VR),
      .CLEAR_COLOR (16'h0000)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   int n_assert = 0;
   int n_fail   = 0;

   // Behavioural model: whether a sweep is running, which pixel is next, whether a restart is owed.
   bit m_known    = 1'b0;
   bit m_clearing = 1'b0;
   int m_pos      = 0;
   bit m_pend     = 1'b0;
   int m_count    = 0;
   bit m_done     = 1'b0;
   int done_seen  = 0;
   logic [26:0] seen[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input bit t_rst, input bit fs, input bit en, input bit rv,
                        input logic [26:0] a, input logic [ZW-1:0] d,
                        input logic [15:0] c, input bit rdy);
      bit req;
      rst_in             = t_rst;
      bus.frame_start_in = fs;
      bus.clear_en_in    = en;
      bus.rast_valid_in  = rv;
      bus.rast_addr_in   = a;
      bus.rast_depth_in  = d;
      bus.rast_color_in  = c;
      bus.ready_in       = rdy;
      #3;
      if (m_known) begin
         chk("valid_out",       64'(bus.valid_out),       64'(m_clearing ? 1'b1 : rv));
         chk("addr_out",        64'(bus.addr_out),        m_clearing ? 64'(m_pos) : 64'(a));
         chk("depth_out",       64'(bus.depth_out),       m_clearing ? 64'(15'h7fff) : 64'(d));
         chk("color_out",       64'(bus.color_out),       m_clearing ? 64'(16'h0000) : 64'(c));
         chk("rast_ready_out",  64'(bus.rast_ready_out),  64'(m_clearing ? 1'b0 : rdy));
         chk("force_write_out", 64'(bus.force_write_out), 64'(m_clearing));
         chk("clearing_out",    64'(bus.clearing_out),    64'(m_clearing));
         chk("clear_done_out",  64'(bus.clear_done_out),  64'(m_done));
         chk("frame_count_out", 64'(bus.frame_count_out), 64'(m_count % 65536));
         if (bus.clear_done_out === 1'b1) begin
            done_seen++;
            chk("sweep_beats", 64'(seen.size()), 64'(DEPTH));
            for (int i = 0; i < seen.size(); i++) chk("sweep_order", 64'(seen[i]), 64'(i));
            seen.delete();
         end
         if (bus.force_write_out === 1'b1 && bus.valid_out === 1'b1 && rdy)
            seen.push_back(bus.addr_out);
      end
      @(posedge clk_in);
      req = fs && en;
      if (t_rst) begin
         m_known = 1'b1; m_clearing = 1'b0; m_pos = 0; m_pend = 1'b0;
         m_count = 0; m_done = 1'b0;
         seen.delete();
      end else begin
         m_done = 1'b0;
         if (!m_clearing) begin
            if (req) begin m_clearing = 1'b1; m_pos = 0; end
         end else if (rdy && m_pos == DEPTH - 1) begin
            m_done  = 1'b1;
            m_count = m_count + 1;
            m_pos   = 0;
            if (!(m_pend || req)) m_clearing = 1'b0;
            m_pend  = 1'b0;
         end else begin
            if (rdy) m_pos = m_pos + 1;
            if (req) m_pend = 1'b1;
         end
      end
      #1;
   endtask

   function automatic logic [26:0] r_addr();
      return 27'($urandom);
   endfunction

   initial begin
      int target;
      // Reset for two cycles, then a pass-through beat at address 5.
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 27'd0, 15'd0, 16'd0, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 27'd0, 15'd0, 16'd0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 27'd5, 15'h1234, 16'hbeef, 1'b1);
      chk("reset_count", 64'(bus.frame_count_out), 64'd0);

      // Basic clear with ready held high.
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 27'd9, 15'd3, 16'h1111, 1'b1);
      for (int i = 0; i < DEPTH + 1; i++)
         cycle(1'b0, 1'b0, 1'b1, 1'b1, r_addr(), 15'($urandom), 16'($urandom), 1'b1);
      chk("basic_done_pulses", 64'(done_seen), 64'd1);
      chk("basic_count", 64'(bus.frame_count_out), 64'd1);
      chk("basic_back_to_pass", 64'(bus.clearing_out), 64'd0);

      // Backpressure: ready toggles every cycle during the sweep.
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'd0, 15'd0, 16'd0, 1'b1);
      for (int i = 0; i < 40 && done_seen < 2; i++)
         cycle(1'b0, 1'b0, 1'b1, 1'b0, r_addr(), 15'd0, 16'd0, (i % 2) == 1);
      chk("bp_done_pulses", 64'(done_seen), 64'd2);
      chk("bp_count", 64'(bus.frame_count_out), 64'd2);

      // Overlap: three requests mid-sweep collapse into one restart.
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'd0, 15'd0, 16'd0, 1'b1);
      for (int i = 0; i < 60 && done_seen < 4; i++)
         cycle(1'b0, (i == 2 || i == 4 || i == 5), 1'b1, 1'b0, 27'd0, 15'd0, 16'd0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 27'd0, 15'd0, 16'd0, 1'b1);
      chk("ovl_done_pulses", 64'(done_seen), 64'd4);
      chk("ovl_count", 64'(bus.frame_count_out), 64'd4);
      chk("ovl_single_restart", 64'(bus.clearing_out), 64'd0);

      // clear_en low: request ignored, pass-through continues.
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 27'd77, 15'd7, 16'h7777, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 27'd78, 15'd8, 16'h8888, 1'b1);
      chk("noen_clearing", 64'(bus.clearing_out), 64'd0);
      chk("noen_count", 64'(bus.frame_count_out), 64'd4);

      // Reset while addr 3 is presented abandons the sweep; next request sweeps from 0.
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'd0, 15'd0, 16'd0, 1'b1);
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 1'b0, 1'b1, 1'b0, 27'd0, 15'd0, 16'd0, 1'b1);
      chk("rst_mid_addr", 64'(bus.addr_out), 64'd3);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 27'd0, 15'd0, 16'd0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 27'd0, 15'd0, 16'd0, 1'b1);
      chk("rst_mid_count", 64'(bus.frame_count_out), 64'd0);
      chk("rst_mid_no_done", 64'(done_seen), 64'd4);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'd0, 15'd0, 16'd0, 1'b1);
      for (int i = 0; i < 30 && done_seen < 5; i++)
         cycle(1'b0, 1'b0, 1'b1, 1'b0, 27'd0, 15'd0, 16'd0, 1'b1);
      chk("rst_resweep_done", 64'(done_seen), 64'd5);
      chk("rst_resweep_count", 64'(bus.frame_count_out), 64'd1);

      // Randomized traffic against the model.
      target = done_seen;
      for (int i = 0; i < 600; i++)
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 3) != 0), 1'($urandom), r_addr(),
               15'($urandom), 16'($urandom), 1'($urandom));
      chk("rand_some_sweeps", 64'(done_seen > target), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
